bus_write_arbiter: RTL
======================

Name: bus_write_arbiter

Overview:
- Shares the single-transfer-per-cycle PE data bus among NUM_ELEM source PEs.
- Grants are round-robin. Each source is guarded by a credit counter that mirrors free space in its receiving per-source read FIFO.
- Drives the bus triple (data, source address, valid) that every per-PE bus reader captures. Credits return when a receiver pops that source's FIFO.

Parameters:
- DATA_LEN, 16, bus data width.
- BUS_ADDR_LEN, 3, source address width; NUM_ELEM <= 2^BUS_ADDR_LEN.
- NUM_ELEM, 8, number of source PEs.
- FIFO_DEPTH, 8, receiver FIFO depth per source; initial credit count.
- SRC_MASK, 8'h00, bit i set means source i is never granted (no receiving FIFO).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- stall  in  1  freezes arbitration; no grant while high.
- req  in  NUM_ELEM  per-source request; level, held until acked.
- req_data  in  NUM_ELEM*DATA_LEN  per-source payload, slice i = [i*DATA_LEN +: DATA_LEN].
- ack  out  NUM_ELEM  one-hot combinational grant; requester pops on ack.
- credit_ret  in  NUM_ELEM  per-source one-cycle pulse: receiver popped one entry of source i.
- bus_data  out  DATA_LEN  registered bus payload.
- bus_addr  out  BUS_ADDR_LEN  registered index of the granted source.
- bus_valid  out  1  registered bus strobe.
- credit_empty  out  NUM_ELEM  bit i high when credit[i]==0.
- credit_err  out  1  sticky: a credit return arrived while the counter was already full.

Behaviour:
- Decided: reset rstn, asynchronous, active-low; clock clk.
- Reset values:
  - bus_data=0, bus_addr=0, bus_valid=0, credit_err=0.
  - rr_ptr=0.
  - credit[i]=FIFO_DEPTH for all i, so credit_empty=0.
  - Masked sources also hold FIFO_DEPTH and are never granted.
- Eligibility: eligible[i] = req[i] & ~SRC_MASK[i] & (credit[i]!=0) & ~stall.
- Grant selection:
  - Grant the first eligible index scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_ELEM; rr_ptr itself has top priority.
  - ack is asserted in the same cycle, one-hot or zero. It never asserts for a masked, credit-less or non-requesting source, nor during stall.
- Grant to source g in cycle N; all updates land at edge N+1:
  - bus_data <= req_data slice g; bus_addr <= g; bus_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_ELEM; when g = NUM_ELEM-1, the pointer wraps to 0.
- Latency: request to bus_valid is 1 cycle; at most one transfer per cycle, so back-to-back grants give continuous bus_valid.
- No grant in cycle N: bus_valid <= 0; bus_data and bus_addr hold; rr_ptr holds.
- Stall: no grants and bus_valid falls the next cycle. credit_ret is still processed. Requests are not lost, because req stays held.
- Credit update per source, every cycle:
  - grant only: decrement.
  - credit_ret only: increment, saturating at FIFO_DEPTH.
  - both in the same cycle: unchanged.
  - credit_ret with credit==FIFO_DEPTH and no grant: value holds and credit_err sets; it clears only on reset.
- Counter width: $clog2(FIFO_DEPTH+1). credit_empty is decoded combinationally from the counter registers.
- Zero credit: a requester with zero credit is skipped and the scan moves to the next eligible source, so there is no head-of-line blocking. The requester becomes eligible in the cycle after its credit_ret edge.
- Fairness: a continuously eligible source is granted within NUM_ELEM cycles.
- Reset mid-operation: all state returns to reset values immediately. In-flight credits are forgotten; receivers are reset by the same rstn.

Test Plan:
- Defaults plus SRC_MASK=8'h81, FIFO_DEPTH=4. Hold req=8'hFF with distinct data per source -> ack sequence 1,2,3,4,5,6,1,...; bus_addr follows one cycle later; bus_valid continuous; sources 0 and 7 are never acked.
- Only req[3] held, no credit_ret -> exactly 4 grants on consecutive cycles. Then credit_empty[3]=1, ack=0 and bus_valid=0. One credit_ret[3] pulse -> exactly one more grant in the following cycle.
- req[2] and req[5] held, stall high for 3 cycles mid-stream -> no ack during stall; bus_valid low one cycle after stall rises; order resumes 2,5,2 with no payload lost or duplicated.
- credit_ret[4] with credit[4]=4 -> credit stays 4, credit_err=1 and stays set. Separately, grant and credit_ret to source 3 in the same cycle -> credit[3] unchanged.
- Wrap check: rr_ptr=6 with req[6] and req[1] set -> grant 6, then 1; rr_ptr wraps through 0 correctly.
- Assert rstn low mid-burst with credits partially consumed -> next edge shows bus_valid=0 and credit_empty=0; after release, the first grant goes to the lowest eligible index at or after 0.

Source files
------------

// File: rtl/bus_write_arbiter.sv
// Round-robin arbiter for the shared PE data bus. Each source is gated by a credit
// counter that tracks free space in its receiving FIFO.
module bus_write_arbiter #(
    parameter int                   DATA_LEN     = 16,
    parameter int                   BUS_ADDR_LEN = 3,
    parameter int                   NUM_ELEM     = 8,
    parameter int                   FIFO_DEPTH   = 8,
    parameter logic [NUM_ELEM-1:0]  SRC_MASK     = '0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         stall,
    input  logic [NUM_ELEM-1:0]          req,
    input  logic [NUM_ELEM*DATA_LEN-1:0] req_data,
    output logic [NUM_ELEM-1:0]          ack,
    input  logic [NUM_ELEM-1:0]          credit_ret,
    output logic [DATA_LEN-1:0]          bus_data,
    output logic [BUS_ADDR_LEN-1:0]      bus_addr,
    output logic                         bus_valid,
    output logic [NUM_ELEM-1:0]          credit_empty,
    output logic                         credit_err
);

    localparam int            CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [BUS_ADDR_LEN-1:0] r_rr_ptr;
    logic [CW-1:0]           r_credit [NUM_ELEM];
    logic                    r_credit_err;
    logic [NUM_ELEM-1:0]     w_elig;
    logic                    w_gnt_vld;
    logic [BUS_ADDR_LEN-1:0] w_gnt_idx;

    // Index p+k reduced modulo NUM_ELEM (k < NUM_ELEM, p < NUM_ELEM).
    function automatic logic [BUS_ADDR_LEN-1:0] wrap_add(input logic [BUS_ADDR_LEN-1:0] p,
                                                         input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_ELEM) s = s - NUM_ELEM;
        return BUS_ADDR_LEN'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_ELEM; i++) begin
            w_elig[i]       = req[i] & ~SRC_MASK[i] & (r_credit[i] != '0) & ~stall;
            credit_empty[i] = (r_credit[i] == '0);
        end
    end

    // Scan from the far end back toward rr_ptr so the closest eligible index wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_ELEM - 1; k >= 0; k--) begin
            if (w_elig[wrap_add(r_rr_ptr, k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = wrap_add(r_rr_ptr, k);
            end
        end
    end

    assign ack        = w_gnt_vld ? (NUM_ELEM'(1) << w_gnt_idx) : '0;
    assign credit_err = r_credit_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_data  <= '0;
            bus_addr  <= '0;
            bus_valid <= 1'b0;
            r_rr_ptr  <= '0;
        end else begin
            bus_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                bus_data <= req_data[w_gnt_idx*DATA_LEN +: DATA_LEN];
                bus_addr <= w_gnt_idx;
                r_rr_ptr <= wrap_add(w_gnt_idx, 1);
            end
        end
    end

    // A grant and a return in the same cycle cancel out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_credit_err <= 1'b0;
            for (int i = 0; i < NUM_ELEM; i++) r_credit[i] <= FULL;
        end else begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                if (ack[i] && !credit_ret[i]) begin
                    r_credit[i] <= r_credit[i] - CW'(1);
                end else if (credit_ret[i] && !ack[i]) begin
                    if (r_credit[i] == FULL) r_credit_err <= 1'b1;
                    else                     r_credit[i]  <= r_credit[i] + CW'(1);
                end
            end
        end
    end

endmodule
